// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch I, load/store D) sharing one single-port memory with 1-cycle read latency.
// Optional macro ARB_ROUND_ROBIN_EN swaps the D-priority/anti-starvation policy for round-robin on contention.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_W-1:0]     i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    output logic [DATA_W-1:0]     i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_W/8-1:0]   d_be,
    input  logic [ADDR_W-1:0]     d_addr,
    input  logic [DATA_W-1:0]     d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [DATA_W-1:0]     d_rdata,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_W/8-1:0]   m_be,
    output logic [ADDR_W-1:0]     m_addr,
    output logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W-1:0]     m_rdata
);

    localparam int BE_W = DATA_W / 8;

    logic grant_i_s;
    logic grant_d_s;
    logic resp_v_r;
    logic resp_owner_r;
    logic resp_we_r;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_d_r;

    // Grant decision: on contention serve the port not granted most recently.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (rst) begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end else if (i_req && d_req) begin
            grant_d_s = ~last_d_r;
            grant_i_s = last_d_r;
        end else begin
            grant_i_s = i_req;
            grant_d_s = d_req;
        end
    end

    // Last-granted tracker; resets to I so D wins the first contention.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_d_r <= 1'b0;
        end else if (grant_d_s) begin
            last_d_r <= 1'b1;
        end else if (grant_i_s) begin
            last_d_r <= 1'b0;
        end else begin
            last_d_r <= last_d_r;
        end
    end
`else
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [SW-1:0] streak_r;
    logic          starved_s;

    assign starved_s = (streak_r == LIMIT_C);

    // Grant decision: D first, unless I has waited through a full streak of D grants.
    always_comb begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
        if (rst) begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
        end else if (i_req && d_req) begin
            grant_i_s = starved_s;
            grant_d_s = ~starved_s;
        end else begin
            grant_i_s = i_req;
            grant_d_s = d_req;
        end
    end

    // Streak of D grants while I waits; saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_i_s || !i_req) begin
            streak_r <= {SW{1'b0}};
        end else if (grant_d_s && (streak_r != LIMIT_C)) begin
            streak_r <= streak_r + SW'(1);
        end else begin
            streak_r <= streak_r;
        end
    end
`endif

    assign i_gnt = grant_i_s;
    assign d_gnt = grant_d_s;

    // Memory request mux: granted port drives the memory, idle cycles drive zeros.
    always_comb begin
        m_req   = grant_i_s | grant_d_s;
        m_we    = 1'b0;
        m_be    = {BE_W{1'b0}};
        m_addr  = {ADDR_W{1'b0}};
        m_wdata = {DATA_W{1'b0}};
        if (grant_d_s) begin
            m_we    = d_we;
            m_be    = d_be;
            m_addr  = d_addr;
            m_wdata = d_wdata;
        end else if (grant_i_s) begin
            m_we    = 1'b0;
            m_be    = {BE_W{1'b1}};
            m_addr  = i_addr;
            m_wdata = {DATA_W{1'b0}};
        end else begin
            m_we    = 1'b0;
            m_be    = {BE_W{1'b0}};
            m_addr  = {ADDR_W{1'b0}};
            m_wdata = {DATA_W{1'b0}};
        end
    end

    // Response tracking: remembers owner and op type of the access issued last cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_v_r     <= 1'b0;
            resp_owner_r <= 1'b0;
            resp_we_r    <= 1'b0;
        end else begin
            resp_v_r     <= grant_i_s | grant_d_s;
            resp_owner_r <= grant_d_s;
            resp_we_r    <= grant_d_s & d_we;
        end
    end

    // Gating with rst drops an in-flight response in the cycle reset is asserted.
    assign i_rvalid = resp_v_r & ~resp_owner_r & ~rst;
    assign d_rvalid = resp_v_r & resp_owner_r & ~rst;
    assign i_rdata  = i_rvalid ? m_rdata : {DATA_W{1'b0}};
    assign d_rdata  = (d_rvalid && !resp_we_r) ? m_rdata : {DATA_W{1'b0}};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port memory between the core's instruction-fetch requester (I) and its load/store requester (D).
- Grants at most one request per cycle. The memory has a fixed 1-cycle read latency. The arbiter routes each response back to its owner.
- Default policy: D has priority, with an anti-starvation counter that forces an I grant after a bounded streak of D grants.
- Sits between the core datapath and a unified instruction/data memory.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 3, maximum consecutive D grants while I is waiting; must be >= 1.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_req  in  1  fetch request; held until granted.
- i_addr  in  ADDR_W  fetch address.
- i_gnt  out  1  fetch granted this cycle (combinational).
- i_rvalid  out  1  fetch data valid.
- i_rdata  out  DATA_W  fetch data.
- d_req  in  1  data request; held, with stable payload, until granted.
- d_we  in  1  1 = store, 0 = load.
- d_be  in  DATA_W/8  byte enables.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  data request granted this cycle (combinational).
- d_rvalid  out  1  load data valid, or store acknowledge.
- d_rdata  out  DATA_W  load data; 0 on store ack.
- m_req  out  1  memory access this cycle.
- m_we  out  1  memory write.
- m_be  out  DATA_W/8  memory byte enables.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  DATA_W  memory write data.
- m_rdata  in  DATA_W  memory read data, valid the cycle after m_req && !m_we.

Behaviour:
- Grant decision is combinational each cycle. While rst=1, i_gnt = d_gnt = 0.
- Only d_req: grant D. Only i_req: grant I. Neither: no grant, m_req = 0.
- Both requests: grant D unless streak == STARVE_LIMIT, in which case grant I.
- streak counter, width $clog2(STARVE_LIMIT+1), reset 0:
  - +1 on a D grant while i_req = 1, saturating at STARVE_LIMIT.
  - Cleared on any I grant, or in any cycle with i_req = 0.
- Memory mux:
  - m_req = i_gnt | d_gnt.
  - On an I grant: m_we = 0, m_be = all ones, m_addr = i_addr, m_wdata = 0.
  - On a D grant: m_we, m_be, m_addr and m_wdata come from the D payload.
  - With no grant, all m_* outputs are 0.
- Response tracking uses registers resp_v and resp_owner (0 = I, 1 = D), both reset to 0. Every grant loads resp_v = 1 and resp_owner = granted port; no grant loads resp_v = 0.
- Response outputs, combinational from the registers, one cycle after the grant:
  - i_rvalid = resp_v & !resp_owner.
  - d_rvalid = resp_v & resp_owner.
  - i_rdata = m_rdata when i_rvalid, else 0.
  - d_rdata = m_rdata when d_rvalid and the granted op was a load (registered resp_we = 0), else 0.
- Fully pipelined: a new grant may issue in the same cycle a response returns. Throughput is 1 access per cycle. Latency from grant to rvalid is exactly 1 cycle.
- Reset values: all rvalid outputs 0, all rdata outputs 0, all gnt outputs 0, all m_* outputs 0, streak 0.
- Reset mid-operation: an in-flight response is discarded; rvalid is 0 in the cycle after rst is sampled high. Requests seen during reset are not granted.
- A requester deasserting req before its grant is legal and is simply not served. The payload is only required stable while req=1 and gnt=0.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: on contention, grant the port that was not granted most recently; last-granted register resets to I, so D wins the first contention. The streak counter is not instantiated and STARVE_LIMIT is ignored.
- Not defined: the D-priority plus starvation-counter policy above.

Test Plan:
- Reset: hold rst=1 for 3 cycles with i_req = d_req = 1 -> i_gnt = d_gnt = 0, m_req = 0, all rvalid 0.
- I-only stream: i_req=1, i_addr 0x00, 0x04, 0x08 on consecutive cycles, memory returning addr+0x100 -> i_gnt=1 each cycle; i_rvalid=1 one cycle later with i_rdata 0x100, 0x104, 0x108; d_rvalid stays 0.
- D store: d_req=1, d_we=1, d_be=4'b0011, d_addr=0x40, d_wdata=0xDEADBEEF -> m_we=1, m_be=0011, m_addr=0x40, m_wdata=0xDEADBEEF; next cycle d_rvalid=1, d_rdata=0.
- Starvation, default build, STARVE_LIMIT=3: i_req and d_req held high for 8 cycles -> grant order D,D,D,I,D,D,D,I.
- Round-robin build (ARB_ROUND_ROBIN_EN): both requests held for 6 cycles -> grant order D,I,D,I,D,I.
- Reset mid-flight: D load to 0x80 granted at cycle N, rst=1 at cycle N+1 -> d_rvalid=0 at N+1; no response is ever delivered for that load.
